// File: rtl/simplerisc_pkg.sv
// Shared constants for the SimpleRisc execute stage: opcodes, control-bus bit
// positions and the reset value of the instruction register.
package simplerisc_pkg;

    localparam int          CB_W           = 22;
    localparam logic [31:0] NOP_IR_DEFAULT = 32'h6800_0000;

    localparam int CB_ST   = 21;
    localparam int CB_LD   = 20;
    localparam int CB_BEQ  = 19;
    localparam int CB_BGT  = 18;
    localparam int CB_RET  = 17;
    localparam int CB_IMM  = 16;
    localparam int CB_WB   = 15;
    localparam int CB_UBR  = 14;
    localparam int CB_CALL = 13;
    localparam int CB_ADD  = 12;
    localparam int CB_SUB  = 11;
    localparam int CB_CMP  = 10;
    localparam int CB_MUL  = 9;
    localparam int CB_DIV  = 8;
    localparam int CB_MOD  = 7;
    localparam int CB_LSL  = 6;
    localparam int CB_LSR  = 5;
    localparam int CB_ASR  = 4;
    localparam int CB_OR   = 3;
    localparam int CB_AND  = 2;
    localparam int CB_NOT  = 1;
    localparam int CB_MOV  = 0;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

endpackage

// File: rtl/simplerisc_alu.sv
// Combinational ALU; the one-hot control bus selects a single operation,
// and an empty selection yields zero.
module simplerisc_alu
    import simplerisc_pkg::*;
(
    input  logic [31:0]     i_a,
    input  logic [31:0]     i_b,
    input  logic [CB_W-1:0] i_cb,
    output logic [31:0]     o_result
);

    logic        w_div_zero;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_unused_cb;

    assign w_div_zero  = (i_b == 32'd0);
    assign w_quot      = w_div_zero ? 32'd0 : 32'($signed(i_a) / $signed(i_b));
    assign w_rem       = w_div_zero ? 32'd0 : 32'($signed(i_a) % $signed(i_b));
    assign w_unused_cb = ^{i_cb[CB_W-1:CB_CALL], i_cb[CB_CMP]};

    always_comb begin
        o_result = 32'd0;
        if (i_cb[CB_ADD])      o_result = i_a + i_b;
        else if (i_cb[CB_SUB]) o_result = i_a - i_b;
        else if (i_cb[CB_MUL]) o_result = i_a * i_b;
        else if (i_cb[CB_DIV]) o_result = w_quot;
        else if (i_cb[CB_MOD]) o_result = w_rem;
        else if (i_cb[CB_LSL]) o_result = i_a << i_b[4:0];
        else if (i_cb[CB_LSR]) o_result = i_a >> i_b[4:0];
        else if (i_cb[CB_ASR]) o_result = 32'($signed(i_a) >>> i_b[4:0]);
        else if (i_cb[CB_OR])  o_result = i_a | i_b;
        else if (i_cb[CB_AND]) o_result = i_a & i_b;
        else if (i_cb[CB_NOT]) o_result = ~i_b;
        else if (i_cb[CB_MOV]) o_result = i_b;
    end

endmodule

// File: rtl/simplerisc_ex_stage.sv
// SimpleRisc execute stage: OF-stage decoder, ALU, branch unit with E/GT
// flags, and the EX/MA pipeline register.
module simplerisc_ex_stage
    import simplerisc_pkg::*;
#(
    parameter logic [31:0] NOP_IR = NOP_IR_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [31:0]     i_of_ir,
    output logic [CB_W-1:0] o_of_control_bus,
    input  logic [31:0]     i_ex_pc,
    input  logic [31:0]     i_ex_branch_target,
    input  logic [31:0]     i_ex_op_a,
    input  logic [31:0]     i_ex_op_b,
    input  logic [31:0]     i_ex_op2,
    input  logic [31:0]     i_ex_ir,
    input  logic [CB_W-1:0] i_ex_control_bus,
    output logic            o_is_branch_taken,
    output logic [31:0]     o_branch_pc,
    output logic [31:0]     o_ma_pc,
    output logic [31:0]     o_ma_alu_result,
    output logic [31:0]     o_ma_op2,
    output logic [31:0]     o_ma_ir,
    output logic [CB_W-1:0] o_ma_control_bus
);

    logic [4:0]      w_opcode;
    logic [CB_W-1:0] w_of_cb;
    logic [31:0]     w_alu_result;
    logic            w_unused_ir;
    logic            r_flag_e;
    logic            r_flag_gt;

    assign w_opcode    = i_of_ir[31:27];
    assign w_unused_ir = ^i_of_ir[25:0];

    always_comb begin
        w_of_cb = '0;
        if (i_reset_n) begin
            case (w_opcode)
                OP_ADD:  begin w_of_cb[CB_ADD] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_SUB:  begin w_of_cb[CB_SUB] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_MUL:  begin w_of_cb[CB_MUL] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_DIV:  begin w_of_cb[CB_DIV] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_MOD:  begin w_of_cb[CB_MOD] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_CMP:  w_of_cb[CB_CMP] = 1'b1;
                OP_AND:  begin w_of_cb[CB_AND] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_OR:   begin w_of_cb[CB_OR]  = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_NOT:  begin w_of_cb[CB_NOT] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_MOV:  begin w_of_cb[CB_MOV] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_LSL:  begin w_of_cb[CB_LSL] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_LSR:  begin w_of_cb[CB_LSR] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_ASR:  begin w_of_cb[CB_ASR] = 1'b1; w_of_cb[CB_WB] = 1'b1; end
                OP_LD:   begin
                    w_of_cb[CB_LD]  = 1'b1;
                    w_of_cb[CB_ADD] = 1'b1;
                    w_of_cb[CB_WB]  = 1'b1;
                end
                OP_ST:   begin w_of_cb[CB_ST]  = 1'b1; w_of_cb[CB_ADD] = 1'b1; end
                OP_BEQ:  w_of_cb[CB_BEQ] = 1'b1;
                OP_BGT:  w_of_cb[CB_BGT] = 1'b1;
                OP_B:    w_of_cb[CB_UBR] = 1'b1;
                OP_CALL: begin
                    w_of_cb[CB_CALL] = 1'b1;
                    w_of_cb[CB_UBR]  = 1'b1;
                    w_of_cb[CB_WB]   = 1'b1;
                end
                OP_RET:  begin w_of_cb[CB_RET] = 1'b1; w_of_cb[CB_UBR] = 1'b1; end
                default: ;
            endcase
            // nop and undefined opcodes keep the bus fully zero, immediate bit included
            if (w_of_cb != '0) w_of_cb[CB_IMM] = i_of_ir[26];
        end
    end

    assign o_of_control_bus = w_of_cb;

    simplerisc_alu u_alu (
        .i_a      (i_ex_op_a),
        .i_b      (i_ex_op_b),
        .i_cb     (i_ex_control_bus),
        .o_result (w_alu_result)
    );

    // Branches in EX see the flags from the previous edge, i.e. from a cmp now entering MA
    assign o_is_branch_taken = i_ex_control_bus[CB_UBR]
                             | (i_ex_control_bus[CB_BEQ] & r_flag_e)
                             | (i_ex_control_bus[CB_BGT] & r_flag_gt);
    assign o_branch_pc = i_ex_control_bus[CB_RET] ? i_ex_op_a : i_ex_branch_target;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_flag_e  <= 1'b0;
            r_flag_gt <= 1'b0;
        end else if (i_ex_control_bus[CB_CMP]) begin
            r_flag_e  <= (i_ex_op_a == i_ex_op_b);
            r_flag_gt <= ($signed(i_ex_op_a) > $signed(i_ex_op_b));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ma_pc          <= 32'd0;
            o_ma_alu_result  <= 32'd0;
            o_ma_op2         <= 32'd0;
            o_ma_ir          <= NOP_IR;
            o_ma_control_bus <= '0;
        end else begin
            o_ma_pc          <= i_ex_pc;
            o_ma_alu_result  <= w_alu_result;
            o_ma_op2         <= i_ex_op2;
            o_ma_ir          <= i_ex_ir;
            o_ma_control_bus <= i_ex_control_bus;
        end
    end

endmodule

// File: tb/tb_simplerisc_ex_stage.sv
// Scoreboard bench for the SimpleRisc execute stage: directed vectors push
// expected EX/MA contents, a monitor pops and compares them.
module tb_simplerisc_ex_stage;

    localparam logic [31:0] NOP = 32'h6800_0000;

    localparam logic [21:0] B_ST   = 22'h200000;
    localparam logic [21:0] B_LD   = 22'h100000;
    localparam logic [21:0] B_BEQ  = 22'h080000;
    localparam logic [21:0] B_BGT  = 22'h040000;
    localparam logic [21:0] B_RET  = 22'h020000;
    localparam logic [21:0] B_IMM  = 22'h010000;
    localparam logic [21:0] B_WB   = 22'h008000;
    localparam logic [21:0] B_UBR  = 22'h004000;
    localparam logic [21:0] B_CALL = 22'h002000;
    localparam logic [21:0] B_ADD  = 22'h001000;
    localparam logic [21:0] B_SUB  = 22'h000800;
    localparam logic [21:0] B_CMP  = 22'h000400;
    localparam logic [21:0] B_MUL  = 22'h000200;
    localparam logic [21:0] B_DIV  = 22'h000100;
    localparam logic [21:0] B_MOD  = 22'h000080;
    localparam logic [21:0] B_LSL  = 22'h000040;
    localparam logic [21:0] B_LSR  = 22'h000020;
    localparam logic [21:0] B_ASR  = 22'h000010;
    localparam logic [21:0] B_OR   = 22'h000008;
    localparam logic [21:0] B_AND  = 22'h000004;
    localparam logic [21:0] B_NOT  = 22'h000002;
    localparam logic [21:0] B_MOV  = 22'h000001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] op2;
        logic [31:0] ir;
        logic [21:0] cb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] of_ir;
    logic [21:0] of_cb;
    logic [31:0] ex_pc, ex_tgt, ex_a, ex_b, ex_op2, ex_ir;
    logic [21:0] ex_cb;
    logic        taken;
    logic [31:0] bpc;
    logic [31:0] ma_pc, ma_alu, ma_op2, ma_ir;
    logic [21:0] ma_cb;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    simplerisc_ex_stage dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_of_ir            (of_ir),
        .o_of_control_bus   (of_cb),
        .i_ex_pc            (ex_pc),
        .i_ex_branch_target (ex_tgt),
        .i_ex_op_a          (ex_a),
        .i_ex_op_b          (ex_b),
        .i_ex_op2           (ex_op2),
        .i_ex_ir            (ex_ir),
        .i_ex_control_bus   (ex_cb),
        .o_is_branch_taken  (taken),
        .o_branch_pc        (bpc),
        .o_ma_pc            (ma_pc),
        .o_ma_alu_result    (ma_alu),
        .o_ma_op2           (ma_op2),
        .o_ma_ir            (ma_ir),
        .o_ma_control_bus   (ma_cb)
    );

    always #5 clk = ~clk;

    // Monitor: anything other than a bubble in EX/MA is a result to score
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && ma_ir !== NOP) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ma: got ir=%h alu=%h with nothing expected", ma_ir, ma_alu);
            end else begin
                e = exp_q.pop_front();
                if ({ma_pc, ma_alu, ma_op2, ma_ir, ma_cb} !== e) begin
                    errors++;
                    $display("FAIL ma_reg ir=%h: got pc=%h alu=%h op2=%h ir=%h cb=%h, want pc=%h alu=%h op2=%h ir=%h cb=%h",
                             e.ir, ma_pc, ma_alu, ma_op2, ma_ir, ma_cb, e.pc, e.alu, e.op2, e.ir, e.cb);
                end
            end
        end
    end

    task automatic check_dec(input logic [31:0] ir, input logic [21:0] want, input string name);
        of_ir = ir;
        #1;
        checks++;
        if (of_cb !== want) begin
            errors++;
            $display("FAIL dec_%s: got %h want %h", name, of_cb, want);
        end
    endtask

    task automatic issue(input logic [21:0] cb, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] op2, input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] exp_alu,
                         input bit chk_br, input bit exp_taken, input logic [31:0] exp_bpc,
                         input string name);
        exp_t e;
        @(negedge clk);
        ex_cb = cb; ex_a = a; ex_b = b; ex_op2 = op2; ex_ir = ir; ex_pc = pc; ex_tgt = tgt;
        #1;
        if (chk_br) begin
            checks++;
            if (taken !== exp_taken || bpc !== exp_bpc) begin
                errors++;
                $display("FAIL br_%s: got taken=%b pc=%h want taken=%b pc=%h",
                         name, taken, bpc, exp_taken, exp_bpc);
            end
        end
        e.pc = pc; e.alu = exp_alu; e.op2 = op2; e.ir = ir; e.cb = cb;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        ex_ir = NOP;
        ex_cb = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        of_ir = 32'h7440_0010;
        ex_cb = '0; ex_a = '0; ex_b = '0; ex_op2 = '0; ex_ir = NOP; ex_pc = '0; ex_tgt = '0;
        #12;
        checks++;
        if ({ma_pc, ma_alu, ma_op2, ma_ir, ma_cb} !== {32'd0, 32'd0, 32'd0, NOP, 22'd0}) begin
            errors++;
            $display("FAIL reset_ma: got pc=%h alu=%h op2=%h ir=%h cb=%h", ma_pc, ma_alu, ma_op2, ma_ir, ma_cb);
        end
        check_dec(32'h7440_0010, 22'd0, "in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        check_dec(32'h7440_0010, B_LD | B_ADD | B_IMM | B_WB, "ld_imm");
        check_dec(32'hA800_0000, 22'd0, "op21");
        check_dec(32'h6800_0000, 22'd0, "nop");
        check_dec(32'h0000_0000, B_ADD | B_WB, "add");
        check_dec(32'h7C00_0000, B_ST | B_ADD | B_IMM, "st_imm");
        check_dec(32'h8000_0000, B_BEQ, "beq");
        check_dec(32'h9800_0000, B_CALL | B_UBR | B_WB, "call");
        check_dec(32'hA000_0000, B_RET | B_UBR, "ret");
        check_dec(32'h2C00_0000, B_CMP | B_IMM, "cmp_imm");

        issue(B_ADD, 32'd5, 32'd7, 32'h11, 32'h0000_0001, 32'h1000, 32'h0, 32'd12, 1, 0, 32'h0, "add");
        issue(B_SUB, 32'd3, 32'd5, 32'h22, 32'h0000_0002, 32'h1004, 32'h0, 32'hFFFF_FFFE, 0, 0, 0, "sub");
        issue(B_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0, 32'h0000_0003, 32'h1008, 32'h0, 32'h0001_0000, 0, 0, 0, "mul");
        issue(B_ASR, 32'h8000_0000, 32'd4, 32'h0, 32'h0000_0004, 32'h100C, 32'h0, 32'hF800_0000, 0, 0, 0, "asr");
        issue(B_LSR, 32'h8000_0000, 32'd4, 32'h0, 32'h0000_0005, 32'h1010, 32'h0, 32'h0800_0000, 0, 0, 0, "lsr");
        issue(B_LSL, 32'h0000_0001, 32'h0000_003F, 32'h0, 32'h0000_0006, 32'h1014, 32'h0, 32'h8000_0000, 0, 0, 0, "lsl");
        issue(B_DIV, 32'd100, 32'd0, 32'h0, 32'h0000_0007, 32'h1018, 32'h0, 32'd0, 0, 0, 0, "div0");
        issue(B_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0000_0008, 32'h101C, 32'h0, 32'hFFFF_FFFD, 0, 0, 0, "div");
        issue(B_MOD, 32'hFFFF_FFF9, 32'd3, 32'h0, 32'h0000_0009, 32'h1020, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, "mod");
        issue(B_MOD, 32'd9, 32'd0, 32'h0, 32'h0000_000A, 32'h1024, 32'h0, 32'd0, 0, 0, 0, "mod0");
        issue(B_AND, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h0, 32'h0000_000B, 32'h1028, 32'h0, 32'h00F0_00FF, 0, 0, 0, "and");
        issue(B_OR,  32'hF000_0000, 32'h0000_000F, 32'h0, 32'h0000_000C, 32'h102C, 32'h0, 32'hF000_000F, 0, 0, 0, "or");
        issue(B_NOT, 32'h1234_5678, 32'h0000_FFFF, 32'h0, 32'h0000_000D, 32'h1030, 32'h0, 32'hFFFF_0000, 0, 0, 0, "not");
        issue(B_MOV | B_IMM, 32'h1, 32'hCAFE_0000, 32'h0, 32'h0000_000E, 32'h1034, 32'h0, 32'hCAFE_0000, 0, 0, 0, "mov");

        issue(B_CMP, 32'd3, 32'd3, 32'h0, 32'h2800_0000, 32'h1038, 32'h0, 32'd0, 0, 0, 0, "cmp_eq");
        issue(B_BEQ, 32'h0, 32'h0, 32'h0, 32'h8000_0010, 32'h103C, 32'h40, 32'd0, 1, 1, 32'h40, "beq_taken");
        issue(B_BGT, 32'h0, 32'h0, 32'h0, 32'h8800_0010, 32'h1040, 32'h80, 32'd0, 1, 0, 32'h80, "bgt_eq");
        issue(B_RET | B_UBR, 32'h100, 32'h0, 32'h0, 32'hA000_0000, 32'h1044, 32'h44, 32'd0, 1, 1, 32'h100, "ret");
        issue(B_UBR, 32'h0, 32'h0, 32'h0, 32'h9000_0020, 32'h1048, 32'h200, 32'd0, 1, 1, 32'h200, "b");
        issue(B_CMP, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h2800_0001, 32'h104C, 32'h0, 32'd0, 0, 0, 0, "cmp_neg");
        issue(B_BGT, 32'h0, 32'h0, 32'h0, 32'h8800_0011, 32'h1050, 32'h300, 32'd0, 1, 0, 32'h300, "bgt_signed");
        issue(B_CMP, 32'd9, 32'hFFFF_FFF0, 32'h0, 32'h2800_0002, 32'h1054, 32'h0, 32'd0, 0, 0, 0, "cmp_gt");
        issue(B_BGT, 32'h0, 32'h0, 32'h0, 32'h8800_0012, 32'h1058, 32'h400, 32'd0, 1, 1, 32'h400, "bgt_taken");
        issue(B_BEQ, 32'h0, 32'h0, 32'h0, 32'h8000_0013, 32'h105C, 32'h500, 32'd0, 1, 0, 32'h500, "beq_ne");

        issue(B_CMP, 32'd7, 32'd7, 32'h55, 32'h2800_0003, 32'h1060, 32'h0, 32'd0, 0, 0, 0, "cmp_pre_rst");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ma_pc, ma_alu, ma_op2, ma_ir, ma_cb} !== {32'd0, 32'd0, 32'd0, NOP, 22'd0}) begin
            errors++;
            $display("FAIL midrun_reset: got pc=%h alu=%h op2=%h ir=%h cb=%h", ma_pc, ma_alu, ma_op2, ma_ir, ma_cb);
        end
        check_dec(32'h0000_0000, 22'd0, "midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(B_BEQ, 32'h0, 32'h0, 32'h0, 32'h8000_0014, 32'h1064, 32'h600, 32'd0, 1, 0, 32'h600, "beq_after_rst");
        issue(B_ADD | B_LD, 32'h200, 32'h8, 32'h66, 32'h7000_0001, 32'h1068, 32'h0, 32'h208, 1, 0, 32'h0, "ld_resume");

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results still pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
